// File: rtl/alu_microsequencer_if.sv
// rtl/alu_microsequencer_if.sv - host/datapath-facing bundle of the ALU microsequencer
interface alu_microsequencer_if #(
  parameter int AW = 3
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [7:0]    prog_data;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic          ld_a;
  logic          ld_b;
  logic          ld_c;
  logic          ld_x;
  logic          ld_r;
  logic          ld_alu_out;
  logic [1:0]    alu_select_a;
  logic [1:0]    alu_select_b;
  logic          alu_op;
  logic          busy;
  logic          done;
  logic          overrun;

  modport master (
    output prog_we, prog_addr, prog_data, start, in_valid,
    input  in_ready, ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out,
    input  alu_select_a, alu_select_b, alu_op, busy, done, overrun
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, start, in_valid,
    output in_ready, ld_a, ld_b, ld_c, ld_x, ld_r, ld_alu_out,
    output alu_select_a, alu_select_b, alu_op, busy, done, overrun
  );
endinterface

// File: rtl/alu_microsequencer.sv
// rtl/alu_microsequencer.sv - programmable controller issuing one A/B/C/X/R ALU micro-op per cycle
module alu_microsequencer #(
  parameter int PROG_DEPTH = 8
) (
  input logic              clk,
  input logic              resetn,
  alu_microsequencer_if.slave bus
);
  localparam int AW = $clog2(PROG_DEPTH);
  localparam logic [AW-1:0] LAST_PC = AW'(PROG_DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_t;

  state_t        state;
  logic [1:0]    opidx;
  logic [AW-1:0] pc;
  logic          overrun_q;
  logic [7:0]    prog [PROG_DEPTH];
  logic [7:0]    word;

  assign word = prog[pc];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_IDLE;
      opidx     <= '0;
      pc        <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < PROG_DEPTH; i++) prog[i] <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          // A write in the start cycle commits before the run reads the store.
          if (bus.prog_we) prog[bus.prog_addr] <= bus.prog_data;
          if (bus.start) begin
            state <= S_LOAD;
            opidx <= '0;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            opidx <= opidx + 2'd1;
            if (opidx == 2'd3) begin
              state <= S_EXEC;
              pc    <= '0;
            end
          end
        end
        S_EXEC: begin
          if (word[0] || pc == LAST_PC) begin
            state     <= S_DONE;
            overrun_q <= ~word[0];
          end else begin
            pc <= pc + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready     = 1'b0;
    bus.ld_a         = 1'b0;
    bus.ld_b         = 1'b0;
    bus.ld_c         = 1'b0;
    bus.ld_x         = 1'b0;
    bus.ld_r         = 1'b0;
    bus.ld_alu_out   = 1'b0;
    bus.alu_select_a = 2'd0;
    bus.alu_select_b = 2'd0;
    bus.alu_op       = 1'b0;
    bus.busy         = (state != S_IDLE);
    bus.done         = (state == S_DONE);
    bus.overrun      = (state == S_DONE) && overrun_q;
    case (state)
      S_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          case (opidx)
            2'd0: bus.ld_a = 1'b1;
            2'd1: bus.ld_b = 1'b1;
            2'd2: bus.ld_c = 1'b1;
            2'd3: bus.ld_x = 1'b1;
          endcase
        end
      end
      S_EXEC: begin
        bus.alu_op       = word[7];
        bus.alu_select_a = word[6:5];
        bus.alu_select_b = word[4:3];
        case (word[2:1])
          2'd0: begin bus.ld_a = 1'b1; bus.ld_alu_out = 1'b1; end
          2'd1: begin bus.ld_b = 1'b1; bus.ld_alu_out = 1'b1; end
          2'd2: bus.ld_r = 1'b1;
          2'd3: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_alu_microsequencer.sv
// tb/tb_alu_microsequencer.sv - bench for alu_microsequencer with a datapath model and program interpreter
module tb_alu_microsequencer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] data_in = 8'h00;
  always #5 clk = ~clk;

  alu_microsequencer_if #(.AW(3)) bus ();
  alu_microsequencer #(.PROG_DEPTH(8)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks = 0;
  int failures = 0;

  // Datapath stand-in driven purely by the sequencer's control outputs.
  logic [7:0] dp_a = 0, dp_b = 0, dp_c = 0, dp_x = 0, dp_r = 0;

  function automatic logic [7:0] pick(input logic [1:0] s);
    case (s)
      2'd0: return dp_a;
      2'd1: return dp_b;
      2'd2: return dp_c;
      default: return dp_x;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [7:0] oa, ob, res;
    oa  = pick(bus.alu_select_a);
    ob  = pick(bus.alu_select_b);
    res = bus.alu_op ? 8'(oa * ob) : 8'(oa + ob);
    if (bus.ld_a) dp_a <= bus.ld_alu_out ? res : data_in;
    if (bus.ld_b) dp_b <= bus.ld_alu_out ? res : data_in;
    if (bus.ld_c) dp_c <= data_in;
    if (bus.ld_x) dp_x <= data_in;
    if (bus.ld_r) dp_r <= res;
  end

  // Cycle-indexed event log.
  int cyc = 0, start_cyc = -1, ldr_cyc = -1, done_cyc = -1;
  int done_cnt = 0, exec_cnt = 0, exec_loads = 0, bad = 0;
  logic ovr_last = 1'b0;
  int load_seq[$];

  always @(posedge clk) begin
    int nl;
    if (resetn) begin
      nl = int'(bus.ld_a) + int'(bus.ld_b) + int'(bus.ld_c) + int'(bus.ld_x);
      if (bus.start && !bus.busy) start_cyc = cyc;
      if (bus.ld_r) ldr_cyc = cyc;
      if (bus.done) begin done_cnt++; done_cyc = cyc; ovr_last = bus.overrun; end
      if (bus.busy && !bus.in_ready && !bus.done) begin
        exec_cnt++;
        if (nl != 0 || bus.ld_r) exec_loads++;
      end
      if (bus.in_ready) begin
        if (bus.in_valid ? (nl != 1) : (nl != 0)) bad++;
        if (bus.ld_alu_out || bus.ld_r) bad++;
        if (bus.ld_a) load_seq.push_back(0);
        if (bus.ld_b) load_seq.push_back(1);
        if (bus.ld_c) load_seq.push_back(2);
        if (bus.ld_x) load_seq.push_back(3);
      end else if (bus.ld_c || bus.ld_x || ((bus.ld_a || bus.ld_b) && !bus.ld_alu_out)) begin
        bad++;
      end
    end
    cyc++;
  end

  // Reference: the bench's own copy of the program, interpreted instruction by instruction.
  logic [7:0] tb_prog [8];
  logic [7:0] m_a = 0, m_b = 0, m_r = 0;

  task automatic ref_run(input logic [7:0] ops [4], output int len, output logic ovr);
    logic [7:0] r [4];
    logic [7:0] w, a, b, res;
    for (int i = 0; i < 4; i++) r[i] = ops[i];
    len = 8; ovr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = tb_prog[i];
      a = r[w[6:5]];
      b = r[w[4:3]];
      res = w[7] ? 8'(a * b) : 8'(a + b);
      if (w[2:1] == 2'd0) r[0] = res;
      else if (w[2:1] == 2'd1) r[1] = res;
      else if (w[2:1] == 2'd2) m_r = res;
      if (w[0]) begin len = i + 1; ovr = 1'b0; break; end
    end
    m_a = r[0];
    m_b = r[1];
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_prog(input int addr, input logic [7:0] data);
    bus.prog_we = 1'b1;
    bus.prog_addr = 3'(addr);
    bus.prog_data = data;
    tb_prog[addr] = data;
    tick();
    bus.prog_we = 1'b0;
  endtask

  task automatic run(input logic [7:0] ops [4], input int gaps [4],
                     input logic wr_en, input logic [7:0] wdata, input logic poke);
    int d0, e0, t, len, gsum;
    logic ovr;
    d0 = done_cnt; e0 = exec_cnt; gsum = 0;
    bus.start = 1'b1;
    if (wr_en) begin
      bus.prog_we = 1'b1; bus.prog_addr = 3'd0; bus.prog_data = wdata; tb_prog[0] = wdata;
    end
    tick();
    bus.start = 1'b0; bus.prog_we = 1'b0;
    check("in_ready_after_start", 32'(bus.in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      repeat (gaps[i]) tick();
      gsum += gaps[i];
      bus.in_valid = 1'b1; data_in = ops[i];
      if (poke && i == 1) bus.start = 1'b1;
      tick();
      bus.in_valid = 1'b0; bus.start = 1'b0;
    end
    if (poke) begin
      bus.prog_we = 1'b1; bus.prog_addr = 3'd0; bus.prog_data = 8'h07;
      tick();
      bus.prog_we = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 60) begin tick(); t++; end
    check("done_seen", 32'(done_cnt - d0), 1);
    ref_run(ops, len, ovr);
    check("exec_cycles", 32'(exec_cnt - e0), 32'(len));
    check("overrun", 32'(ovr_last), 32'(ovr));
    check("latency", 32'(done_cyc - start_cyc), 32'(4 + gsum + len + 1));
    check("reg_r", 32'(dp_r), 32'(m_r));
    check("reg_a", 32'(dp_a), 32'(m_a));
    check("reg_b", 32'(dp_b), 32'(m_b));
  endtask

  logic [7:0] ops [4];
  int gaps [4];
  int ls0, d0;
  logic [7:0] w;

  initial begin
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 1'b0; bus.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tb_prog[i] = 8'h00;
    repeat (2) tick();
    resetn = 1'b1;
    tick();
    check("reset_outputs", 32'({bus.in_ready, bus.busy, bus.done, bus.overrun, bus.ld_a, bus.ld_b,
          bus.ld_c, bus.ld_x, bus.ld_r, bus.ld_alu_out, bus.alu_select_a, bus.alu_select_b, bus.alu_op}), 0);

    // Quadratic: ((A*X)*X + B*X) + C with A,B,C,X = 2,3,4,5.
    write_prog(0, 8'h98); write_prog(1, 8'h98); write_prog(2, 8'hBA);
    write_prog(3, 8'h08); write_prog(4, 8'h15);
    ops = '{8'd2, 8'd3, 8'd4, 8'd5};
    gaps = '{0, 0, 0, 0};
    run(ops, gaps, 1'b0, 8'h00, 1'b0);
    check("quad_r69", 32'(dp_r), 69);
    check("quad_ldr_cycle", 32'(ldr_cyc - start_cyc), 9);
    check("quad_done_cycle", 32'(done_cyc - start_cyc), 10);

    // Operand stalls.
    ls0 = load_seq.size();
    gaps = '{0, 0, 3, 1};
    run(ops, gaps, 1'b0, 8'h00, 1'b0);
    check("stall_load_count", 32'(load_seq.size() - ls0), 4);
    for (int i = 0; i < 4; i++) check("stall_load_order", 32'(load_seq[ls0 + i]), 32'(i));
    check("stall_r69", 32'(dp_r), 69);

    // Ignored start in LOAD and program write in EXEC.
    gaps = '{0, 0, 0, 0};
    run(ops, gaps, 1'b0, 8'h00, 1'b1);
    dp_r = 8'h00; m_r = 8'h00;
    run(ops, gaps, 1'b0, 8'h00, 1'b0);
    check("ignored_word0_r69", 32'(dp_r), 69);

    // Overrun with an all-NOP program.
    for (int i = 0; i < 8; i++) write_prog(i, 8'h06);
    d0 = exec_loads;
    ops = '{8'd9, 8'd8, 8'd7, 8'd6};
    run(ops, gaps, 1'b0, 8'h00, 1'b0);
    check("overrun_flag", 32'(ovr_last), 1);
    check("overrun_no_exec_loads", 32'(exec_loads - d0), 0);

    // Reset during the third instruction.
    d0 = done_cnt;
    bus.start = 1'b1; tick(); bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin bus.in_valid = 1'b1; data_in = ops[i]; tick(); end
    bus.in_valid = 1'b0;
    tick(); tick();
    resetn = 1'b0; tick(); resetn = 1'b1;
    for (int i = 0; i < 8; i++) tb_prog[i] = 8'h00;
    check("midreset_outputs", 32'({bus.in_ready, bus.busy, bus.done, bus.overrun, bus.ld_a, bus.ld_b,
          bus.ld_c, bus.ld_x, bus.ld_r, bus.ld_alu_out, bus.alu_select_a, bus.alu_select_b, bus.alu_op}), 0);
    check("midreset_no_done", 32'(done_cnt - d0), 0);
    ops = '{8'd13, 8'd1, 8'd2, 8'd3};
    run(ops, gaps, 1'b0, 8'h00, 1'b0);
    check("empty_prog_overrun", 32'(ovr_last), 1);

    // Write of word 0 in the start cycle: mul X,X -> R, last.
    ops = '{8'd1, 8'd2, 8'd3, 8'd7};
    run(ops, gaps, 1'b1, 8'hFD, 1'b0);
    check("same_cycle_r49", 32'(dp_r), 49);

    // Randomized programs, operands and stalls.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 8; i++) begin
        w = 8'($urandom);
        w[0] = ($urandom_range(0, 3) == 0);
        write_prog(i, w);
      end
      for (int i = 0; i < 4; i++) begin
        ops[i] = 8'($urandom);
        gaps[i] = int'($urandom_range(0, 2));
      end
      run(ops, gaps, 1'b0, 8'h00, 1'b0);
    end

    check("protocol_violations", 32'(bad), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_microsequencer.md
# alu_microsequencer

Programmable controller for the shared 8-bit A/B/C/X register-file + add/multiply ALU datapath. It replaces a hard-wired evaluation FSM with a small instruction store: a host loads a program, pulses `start`, streams four operands through a valid/ready handshake, and the block then issues one ALU micro-op per cycle. Its load, select and op outputs connect one-to-one to the datapath's control inputs.

## Interface
- `PROG_DEPTH`, 8: number of instruction words; power of two, 2..16; `AW = $clog2(PROG_DEPTH)`.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `prog_we`  in  1  program write strobe; honoured only in IDLE.
- `prog_addr`  in  AW  program write address.
- `prog_data`  in  8  instruction word, laid out as follows:
  - `[7]` op: 0 = add, 1 = mul.
  - `[6:5]` src_a: 0 = A, 1 = B, 2 = C, 3 = X.
  - `[4:3]` src_b: same encoding as src_a.
  - `[2:1]` dst: 0 = A, 1 = B, 2 = R, 3 = NOP.
  - `[0]` last.
- `start`  in  1  begin a run; honoured only in IDLE.
- `in_valid`  in  1  operand beat valid; the data itself travels on the datapath `data_in`.
- `in_ready`  out  1  operand beat accepted this cycle when `in_valid & in_ready`.
- `ld_a`, `ld_b`, `ld_c`, `ld_x`, `ld_r`  out  1 each  datapath register loads.
- `ld_alu_out`  out  1  A/B load source select: 1 = ALU, 0 = `data_in`.
- `alu_select_a`, `alu_select_b`  out  2 each  ALU operand muxes.
- `alu_op`  out  1  0 = add, 1 = mul.
- `busy`  out  1  high in LOAD, EXEC and DONE.
- `done`  out  1  one-cycle pulse at the end of a run.
- `overrun`  out  1  high with `done` when the run ended at address `PROG_DEPTH-1` with `last` clear.

## Operation
- Program store: `PROG_DEPTH` x 8 registers, all cleared to 8'h00 on reset.
  - Written at the clock edge when `prog_we` is high in IDLE.
  - Writes in any other state are dropped.
- FSM states are IDLE, LOAD, EXEC and DONE. Registered state: `opidx` (2 bits) and `pc` (AW bits).
- IDLE:
  - All control outputs are 0.
  - When `start` is high: go to LOAD, `opidx` <= 0.
- LOAD:
  - `in_ready` = 1.
  - When `in_valid` is high, assert exactly one of `ld_a`, `ld_b`, `ld_c`, `ld_x`, selected by `opidx` 0..3. This path is combinational from `in_valid` and `ld_alu_out` = 0.
  - Each accepted beat increments `opidx`.
  - On the beat with `opidx` = 3: go to EXEC, `pc` <= 0.
  - With `in_valid` low, the block stalls indefinitely; no loads are asserted.
- EXEC: decode `prog[pc]` combinationally.
  - `alu_op`, `alu_select_a` and `alu_select_b` come straight from the word.
  - dst = A: `ld_a` = 1 and `ld_alu_out` = 1.
  - dst = B: `ld_b` = 1 and `ld_alu_out` = 1.
  - dst = R: `ld_r` = 1 and `ld_alu_out` = 0.
  - dst = NOP: no loads.
  - If `last` = 1 or `pc` = `PROG_DEPTH-1`: go to DONE and latch `overrun_q` = ~`last`. Otherwise `pc` <= `pc`+1.
- DONE:
  - `done` = 1 and `overrun` = `overrun_q`; all loads are 0.
  - Go to IDLE next cycle.
- Never asserted: `ld_c`/`ld_x` outside LOAD, and A/B loads with `ld_alu_out` = 0 outside LOAD.
- `start` outside IDLE and `in_valid` outside LOAD are ignored.
- Arithmetic is the datapath's: results are 8 bits, modulo 256. The sequencer does no arithmetic.
- Reset has priority over all activity, including mid-LOAD and mid-EXEC:
  - state goes to IDLE; `pc`, `opidx` and `overrun_q` go to 0; the program is cleared.
  - All outputs reset to 0, including `in_ready`, `busy`, `done` and `overrun`.

## Timing
- `start` sampled high at edge N puts the block in LOAD from cycle N+1, with `in_ready` high in that cycle.
- One operand is accepted per cycle at most. With back-to-back `in_valid`, the four loads occur in cycles N+1..N+4.
- For a program whose `last` bit sits at index k: EXEC occupies k+1 cycles, one instruction per cycle, with the register write at the edge closing each cycle.
- `done` is asserted in the cycle after the final EXEC cycle. IDLE resumes the cycle after that, so a new `start` can be accepted in the cycle following `done`.
- Minimum `start`-to-`done` latency is 4 + (k+1) + 1 cycles.
- `prog_we` and `start` high in the same IDLE cycle: the write commits at that edge, and the run executes the updated word.
- All control outputs are combinational from state and program registers, plus `in_valid` in LOAD. The datapath samples them at the next edge.

## Test plan
- Quadratic evaluation:
  - Stimulus: program mul A,X→A; mul A,X→A; mul B,X→B; add A,B→A; add A,C→R (last). Operands 2, 3, 4, 5 sent back-to-back.
  - Required: `ld_r` is seen in cycle N+9 and R = 69; `done` pulses at N+10 with `overrun` = 0.
- Operand stalls:
  - Stimulus: `in_valid` gaps of 0, 3 and 1 cycles between beats.
  - Required: exactly four single-cycle `ld_a`/`ld_b`/`ld_c`/`ld_x` pulses, in that order, each coincident with `in_valid`. No loads are asserted during gaps.
- Overrun:
  - Stimulus: all eight words have `last` = 0, with dst = NOP.
  - Required: EXEC lasts 8 cycles with no loads; `done` = 1 and `overrun` = 1 together.
- Ignored requests:
  - Stimulus: `prog_we` to address 0 during EXEC, and `start` during LOAD.
  - Required: the next run reads the original word 0; the current run's cycle count is unchanged.
- Reset mid-EXEC:
  - Stimulus: `resetn` low for one cycle during instruction 2.
  - Required: the next cycle shows IDLE with all outputs 0 and `busy` = 0. A following `start` with an empty program ends with `overrun` = 1 after 8 EXEC cycles, because every word is 8'h00 (add A,A→A, `last` = 0).
- Same-cycle write and start:
  - Stimulus: `prog_we` of word 0 = 8'b1_11_11_10_1 (mul X,X→R, last) in the same cycle as `start`; X = 7.
  - Required: a single EXEC cycle, then R = 49.
